// File: rtl/delay_calibrator.sv
// Sweeps the iCE40 PLL fine delay 0..15 and finds the first sampled level flip.
// Optional macro DELAY_CAL_HISTORY_EN builds the per-step history register.
module delay_calibrator #(
  parameter int unsigned WINDOW_LOG2    = 8,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter logic [3:0]  RELATIVE_DELAY = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sample_in,
  output logic [7:0]  delay,
  output logic        busy,
  output logic        done,
  output logic        edge_found,
  output logic [3:0]  edge_delay,
  output logic [15:0] history
);

  localparam int unsigned CW = WINDOW_LOG2 + 1;
  localparam logic [CW-1:0] HALF =
    CW'(2 ** (WINDOW_LOG2 - 1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_EVAL,
    S_FINISH
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                   r_sync1;
  logic                   r_sync2;
  logic [3:0]             r_step;
  logic [3:0]             r_delay;
  logic [7:0]             r_settle;
  logic [WINDOW_LOG2-1:0] r_win;
  logic [CW-1:0]          r_ones;
  logic                   r_prev;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_found;
  logic [3:0]             r_edge;

  logic w_bit;
  logic w_flip;
  logic w_settle_last;
  logic w_win_last;
  logic w_start_ok;

  assign w_bit         = r_ones > HALF;
  assign w_flip        = (r_step != 4'h0) && (w_bit != r_prev);
  assign w_settle_last = r_settle == 8'(SETTLE_CYCLES - 1);
  assign w_win_last    = &r_win;
  assign w_start_ok    = (r_state == S_IDLE) && start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= sample_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_next = S_SETTLE;
      S_SETTLE:  if (w_settle_last) w_next = S_MEASURE;
      S_MEASURE: if (w_win_last) w_next = S_EVAL;
      S_EVAL: begin
        if (w_flip || r_step == 4'hf) w_next = S_FINISH;
        else                          w_next = S_SETTLE;
      end
      S_FINISH:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step   <= 4'h0;
      r_delay  <= 4'h0;
      r_settle <= 8'h0;
      r_win    <= '0;
      r_ones   <= '0;
      r_prev   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_found  <= 1'b0;
      r_edge   <= 4'h0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_step   <= 4'h0;
            r_delay  <= 4'h0;
            r_settle <= 8'h0;
            r_prev   <= 1'b0;
            r_found  <= 1'b0;
            r_edge   <= 4'h0;
            r_busy   <= 1'b1;
          end
        end
        S_SETTLE: begin
          r_settle <= r_settle + 8'h1;
          if (w_settle_last) begin
            r_ones <= '0;
            r_win  <= '0;
          end
        end
        S_MEASURE: begin
          r_ones <= r_ones + CW'(r_sync2);
          r_win  <= r_win + 1'b1;
        end
        S_EVAL: begin
          if (w_flip) begin
            r_found <= 1'b1;
            r_edge  <= r_step;
          end else if (r_step != 4'hf) begin
            r_prev   <= w_bit;
            r_step   <= r_step + 4'h1;
            r_delay  <= r_step + 4'h1;
            r_settle <= 8'h0;
          end
        end
        S_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_delay <= r_found ? r_edge : 4'h0;
        end
        default: ;
      endcase
    end
  end

`ifdef DELAY_CAL_HISTORY_EN
  logic [15:0] r_hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  r_hist <= 16'h0;
    else if (w_start_ok)         r_hist <= 16'h0;
    else if (r_state == S_EVAL)  r_hist[r_step] <= w_bit;
  end

  assign history = r_hist;
`else
  assign history = 16'h0000;
`endif

  assign delay      = {RELATIVE_DELAY, r_delay};
  assign busy       = r_busy;
  assign done       = r_done;
  assign edge_found = r_found;
  assign edge_delay = r_edge;

endmodule

// File: tb/tb_delay_calibrator.sv
// Directed bench for delay_calibrator at default parameters.
// Expected history depends on DELAY_CAL_HISTORY_EN.
module tb_delay_calibrator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        sample_in = 1'b0;
  logic [7:0]  delay;
  logic        busy;
  logic        done;
  logic        edge_found;
  logic [3:0]  edge_delay;
  logic [15:0] history;

  int n_checks = 0;
  int n_pass   = 0;
  int mode     = 0;

  localparam int STEP_LAT = 16 + 256 + 1;
  localparam int FULL_LAT = 16 * STEP_LAT + 1;
  localparam int EDGE_LAT = 7 * STEP_LAT + 1;

`ifdef DELAY_CAL_HISTORY_EN
  localparam logic [15:0] HIST6 = 16'h0040;
`else
  localparam logic [15:0] HIST6 = 16'h0000;
`endif

  delay_calibrator dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .sample_in  (sample_in),
    .delay      (delay),
    .busy       (busy),
    .done       (done),
    .edge_found (edge_found),
    .edge_delay (edge_delay),
    .history    (history)
  );

  always #5 clk = ~clk;

  // 0: low, 1: high once delay>=6, 2: toggle every cycle
  always @(negedge clk) begin
    if (mode == 1)      sample_in = (delay[3:0] >= 4'd6);
    else if (mode == 2) sample_in = ~sample_in;
    else                sample_in = 1'b0;
  end

  task automatic run_sweep(output int cyc, output int maxd,
                           output int bad, output logic b1);
    int prev;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; maxd = 0; bad = 0; b1 = 1'b0; prev = 0;
    while (cyc < 6000) begin
      @(posedge clk);
      #1 cyc++;
      if (cyc == 1) b1 = busy;
      if (done) break;
      if (int'(delay[3:0]) != prev && int'(delay[3:0]) != prev + 1)
        bad++;
      prev = int'(delay[3:0]);
      if (prev > maxd) maxd = prev;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #12;
    n_checks++;
    if (delay !== 8'h00) $display("FAIL rst_delay got %h want 00", delay);
    else n_pass++;
    n_checks++;
    if ({busy, done, edge_found} !== 3'b000)
      $display("FAIL rst_flags got %b want 000", {busy, done, edge_found});
    else n_pass++;
    n_checks++;
    if (edge_delay !== 4'h0 || history !== 16'h0)
      $display("FAIL rst_result got %h/%h want 0/0000", edge_delay, history);
    else n_pass++;
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_no_edge;
    int cyc, maxd, bad;
    logic b1;
    mode = 0;
    run_sweep(cyc, maxd, bad, b1);
    n_checks++;
    if (b1 !== 1'b1) $display("FAIL ne_busy got %b want 1", b1);
    else n_pass++;
    n_checks++;
    if (cyc != FULL_LAT) $display("FAIL ne_latency got %0d want %0d", cyc, FULL_LAT);
    else n_pass++;
    n_checks++;
    if (maxd != 15 || bad != 0)
      $display("FAIL ne_steps got max %0d bad %0d want 15/0", maxd, bad);
    else n_pass++;
    n_checks++;
    if (edge_found !== 1'b0 || busy !== 1'b0)
      $display("FAIL ne_found got %b busy %b want 0/0", edge_found, busy);
    else n_pass++;
    n_checks++;
    if (delay !== 8'h00) $display("FAIL ne_delay got %h want 00", delay);
    else n_pass++;
    n_checks++;
    if (history !== 16'h0000) $display("FAIL ne_hist got %h want 0000", history);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) $display("FAIL ne_pulse got %b want 0", done);
    else n_pass++;
  endtask

  task automatic test_edge6;
    int cyc, maxd, bad;
    logic b1;
    mode = 1;
    run_sweep(cyc, maxd, bad, b1);
    n_checks++;
    if (cyc != EDGE_LAT) $display("FAIL e6_latency got %0d want %0d", cyc, EDGE_LAT);
    else n_pass++;
    n_checks++;
    if (edge_found !== 1'b1 || edge_delay !== 4'd6)
      $display("FAIL e6_result got %b/%0d want 1/6", edge_found, edge_delay);
    else n_pass++;
    n_checks++;
    if (delay !== 8'h06) $display("FAIL e6_delay got %h want 06", delay);
    else n_pass++;
    n_checks++;
    if (history !== HIST6) $display("FAIL e6_hist got %h want %h", history, HIST6);
    else n_pass++;
    mode = 0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_half_duty;
    int cyc, maxd, bad;
    logic b1;
    mode = 2;
    run_sweep(cyc, maxd, bad, b1);
    mode = 0;
    n_checks++;
    if (cyc != FULL_LAT) $display("FAIL hd_latency got %0d want %0d", cyc, FULL_LAT);
    else n_pass++;
    n_checks++;
    if (edge_found !== 1'b0 || delay !== 8'h00)
      $display("FAIL hd_result got %b/%h want 0/00", edge_found, delay);
    else n_pass++;
    n_checks++;
    if (history !== 16'h0000) $display("FAIL hd_hist got %h want 0000", history);
    else n_pass++;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc, ndone, first;
    mode = 1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; ndone = 0; first = 0;
    while (cyc < 2500) begin
      @(posedge clk);
      #1 cyc++;
      start = 1'b0;
      if (done) begin
        ndone++;
        if (first == 0) first = cyc;
      end
      if (busy && (cyc % 50 == 0)) start = 1'b1;
    end
    start = 1'b0;
    mode = 0;
    n_checks++;
    if (ndone != 1) $display("FAIL bb_dones got %0d want 1", ndone);
    else n_pass++;
    n_checks++;
    if (first != EDGE_LAT) $display("FAIL bb_latency got %0d want %0d", first, EDGE_LAT);
    else n_pass++;
    n_checks++;
    if (edge_found !== 1'b1 || edge_delay !== 4'd6)
      $display("FAIL bb_result got %b/%0d want 1/6", edge_found, edge_delay);
    else n_pass++;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_mid;
    int cyc, ndone, nbusy;
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (cyc < 3000 && delay[3:0] != 4'd5) begin
      @(posedge clk);
      #1 cyc++;
    end
    n_checks++;
    if (delay[3:0] !== 4'd5) $display("FAIL rm_reach got %0d want 5", delay[3:0]);
    else n_pass++;
    repeat (116) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    n_checks++;
    if (delay !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rm_async got %h/%b/%b want 00/0/0", delay, busy, done);
    else n_pass++;
    n_checks++;
    if (edge_found !== 1'b0 || edge_delay !== 4'h0 || history !== 16'h0)
      $display("FAIL rm_result got %b/%h/%h want 0/0/0000",
               edge_found, edge_delay, history);
    else n_pass++;
    @(negedge clk) reset = 1'b1;
    ndone = 0; nbusy = 0;
    repeat (600) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
      if (busy) nbusy++;
    end
    n_checks++;
    if (ndone != 0 || nbusy != 0)
      $display("FAIL rm_after got done %0d busy %0d want 0/0", ndone, nbusy);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_no_edge;
    test_edge6;
    test_half_duty;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
